// File: rtl/ppi8255.sv
// ppi8255: programmable peripheral interface (8255-style) with mode 0 and
// mode 1 strobed handshake on ports A and B. A group A mode field of 1x is
// handled as mode 1. Port pins arrive through a SYNC_STAGES-deep synchroniser
// and every handshake edge is detected on the synchronised values.
module ppi8255 #(
  parameter logic [7:0] RESET_CTRL   = 8'h9B,
  parameter bit         ENABLE_MODE1 = 1'b1,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       rd,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe,
  input  logic [7:0] pc_in,
  output logic [7:0] pc_out,
  output logic [7:0] pc_oe
);

  // Synchroniser chain for all 24 port pins, oldest stage last.
  logic [23:0] sync_reg [SYNC_STAGES];
  logic [7:0]  pa_sync, pb_sync, pc_sync;
  logic [7:0]  pc_prev_reg;

  logic [6:0]  ctrl_reg;
  logic [7:0]  pa_latch_reg, pb_latch_reg, pc_latch_reg;
  logic [7:0]  pa_in_latch_reg, pb_in_latch_reg;
  logic        inte_a_reg, inte_b_reg;
  logic        ibf_a_reg, ibf_b_reg;
  logic        intr_a_reg, intr_b_reg;
  logic        obf_a_n_reg, obf_b_n_reg;

  logic        a_mode1, b_mode1, a_dir_in, b_dir_in;
  logic [7:0]  pc_fall, pc_rise;
  logic        a_hs_fall, a_hs_rise;
  logic        wr_en, rd_en;
  logic        wr_pa, wr_pb, wr_pc, wr_ctrl, rd_pa, rd_pb;
  logic [2:0]  bsr_bit;
  logic        bsr_inte_a, bsr_inte_b;
  logic [7:0]  pc_oe_c, pc_hs_c, pc_rd_c;

  assign {pc_sync, pb_sync, pa_sync} = sync_reg[SYNC_STAGES-1];

  // Mode decode; with mode 1 disabled both groups behave as mode 0.
  assign a_mode1  = ENABLE_MODE1 && (ctrl_reg[6:5] != 2'b00);
  assign b_mode1  = ENABLE_MODE1 && ctrl_reg[2];
  assign a_dir_in = ctrl_reg[4];
  assign b_dir_in = ctrl_reg[1];

  // Edges of the synchronised port C pins; group A watches PC4 (STB) or PC6 (ACK).
  assign pc_fall   = pc_prev_reg & ~pc_sync;
  assign pc_rise   = ~pc_prev_reg & pc_sync;
  assign a_hs_fall = a_dir_in ? pc_fall[4] : pc_fall[6];
  assign a_hs_rise = a_dir_in ? pc_rise[4] : pc_rise[6];

  assign wr_en   = cs & we;
  assign rd_en   = cs & rd;
  assign wr_pa   = wr_en && (addr == 2'b00);
  assign wr_pb   = wr_en && (addr == 2'b01);
  assign wr_pc   = wr_en && (addr == 2'b10);
  assign wr_ctrl = wr_en && (addr == 2'b11);
  assign rd_pa   = rd_en && (addr == 2'b00);
  assign rd_pb   = rd_en && (addr == 2'b01);

  // Bit set/reset aimed at a STB/ACK position programs the interrupt enable instead.
  assign bsr_bit    = din[3:1];
  assign bsr_inte_a = a_mode1 && (a_dir_in ? (bsr_bit == 3'd4) : (bsr_bit == 3'd6));
  assign bsr_inte_b = b_mode1 && (bsr_bit == 3'd2);

  // Shift port pins through the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= {pc_in, pb_in, pa_in};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  // Register file, handshake flags and control word; a mode-set write overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg        <= RESET_CTRL[6:0];
      pc_prev_reg     <= '0;
      pa_latch_reg    <= '0;
      pb_latch_reg    <= '0;
      pc_latch_reg    <= '0;
      pa_in_latch_reg <= '0;
      pb_in_latch_reg <= '0;
      inte_a_reg      <= 1'b0;
      inte_b_reg      <= 1'b0;
      ibf_a_reg       <= 1'b0;
      ibf_b_reg       <= 1'b0;
      intr_a_reg      <= 1'b0;
      intr_b_reg      <= 1'b0;
      obf_a_n_reg     <= 1'b1;
      obf_b_n_reg     <= 1'b1;
    end else begin
      pc_prev_reg <= pc_sync;

      if (wr_pa) pa_latch_reg <= din;
      if (wr_pb) pb_latch_reg <= din;
      if (wr_pc) pc_latch_reg <= din;

      if (a_mode1) begin
        if (a_dir_in) begin
          // A strobe capturing new data keeps IBF set even if a read lands in the same cycle.
          if (a_hs_fall) begin
            pa_in_latch_reg <= pa_sync;
            ibf_a_reg       <= 1'b1;
          end else if (rd_pa) begin
            ibf_a_reg <= 1'b0;
          end
          if (rd_pa) intr_a_reg <= 1'b0;
          else if (a_hs_rise && inte_a_reg && ibf_a_reg) intr_a_reg <= 1'b1;
        end else begin
          // A CPU write beats a coincident ACK falling edge.
          if (wr_pa) obf_a_n_reg <= 1'b0;
          else if (a_hs_fall) obf_a_n_reg <= 1'b1;
          if (wr_pa) intr_a_reg <= 1'b0;
          else if (a_hs_rise && inte_a_reg && obf_a_n_reg) intr_a_reg <= 1'b1;
        end
      end

      if (b_mode1) begin
        if (b_dir_in) begin
          if (pc_fall[2]) begin
            pb_in_latch_reg <= pb_sync;
            ibf_b_reg       <= 1'b1;
          end else if (rd_pb) begin
            ibf_b_reg <= 1'b0;
          end
          if (rd_pb) intr_b_reg <= 1'b0;
          else if (pc_rise[2] && inte_b_reg && ibf_b_reg) intr_b_reg <= 1'b1;
        end else begin
          if (wr_pb) obf_b_n_reg <= 1'b0;
          else if (pc_fall[2]) obf_b_n_reg <= 1'b1;
          if (wr_pb) intr_b_reg <= 1'b0;
          else if (pc_rise[2] && inte_b_reg && obf_b_n_reg) intr_b_reg <= 1'b1;
        end
      end

      if (wr_ctrl) begin
        if (din[7]) begin
          ctrl_reg        <= din[6:0];
          pa_latch_reg    <= '0;
          pb_latch_reg    <= '0;
          pc_latch_reg    <= '0;
          pa_in_latch_reg <= '0;
          pb_in_latch_reg <= '0;
          inte_a_reg      <= 1'b0;
          inte_b_reg      <= 1'b0;
          ibf_a_reg       <= 1'b0;
          ibf_b_reg       <= 1'b0;
          intr_a_reg      <= 1'b0;
          intr_b_reg      <= 1'b0;
          obf_a_n_reg     <= 1'b1;
          obf_b_n_reg     <= 1'b1;
        end else if (bsr_inte_a) begin
          inte_a_reg <= din[0];
        end else if (bsr_inte_b) begin
          inte_b_reg <= din[0];
        end else begin
          pc_latch_reg[bsr_bit] <= din[0];
        end
      end
    end
  end

  // Port C pin map: handshake outputs replace latch bits, STB/ACK become inputs.
  always_comb begin
    pc_oe_c = {{4{~ctrl_reg[3]}}, {4{~ctrl_reg[0]}}};
    pc_hs_c = pc_latch_reg;
    pc_rd_c = '0;
    if (a_mode1) begin
      pc_oe_c[3] = 1'b1;
      pc_hs_c[3] = intr_a_reg;
      if (a_dir_in) begin
        pc_oe_c[5] = 1'b1;
        pc_hs_c[5] = ibf_a_reg;
        pc_oe_c[4] = 1'b0;
      end else begin
        pc_oe_c[7] = 1'b1;
        pc_hs_c[7] = obf_a_n_reg;
        pc_oe_c[6] = 1'b0;
      end
    end
    if (b_mode1) begin
      pc_oe_c[0] = 1'b1;
      pc_hs_c[0] = intr_b_reg;
      pc_oe_c[1] = 1'b1;
      pc_hs_c[1] = b_dir_in ? ibf_b_reg : obf_b_n_reg;
      pc_oe_c[2] = 1'b0;
    end
    pc_rd_c = (pc_oe_c & pc_hs_c) | (~pc_oe_c & pc_sync);
    if (a_mode1) begin
      if (a_dir_in) pc_rd_c[4] = inte_a_reg;
      else          pc_rd_c[6] = inte_a_reg;
    end
    if (b_mode1) pc_rd_c[2] = inte_b_reg;
  end

  assign pa_out = pa_latch_reg;
  assign pb_out = pb_latch_reg;
  assign pc_out = pc_hs_c;
  assign pa_oe  = a_dir_in ? 8'h00 : 8'hFF;
  assign pb_oe  = b_dir_in ? 8'h00 : 8'hFF;
  assign pc_oe  = pc_oe_c;

  // Read mux: input ports show live pins in mode 0 and the strobed latch in mode 1.
  always_comb begin
    dout = '0;
    case (addr)
      2'b00:   dout = a_dir_in ? (a_mode1 ? pa_in_latch_reg : pa_sync) : pa_latch_reg;
      2'b01:   dout = b_dir_in ? (b_mode1 ? pb_in_latch_reg : pb_sync) : pb_latch_reg;
      2'b10:   dout = pc_rd_c;
      default: dout = {1'b1, ctrl_reg};
    endcase
  end

endmodule
